// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle add/subtract unit.
//   op_e    : operation encoding as presented on the op port
//   state_e : sequencer states (IDLE accepts, CALC walks digits, DONE presents)
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_INC = 2'b10,
    OP_DEC = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/multiword_addsub_digit_adder.sv
// One DIGIT-bit slice of the ripple chain: {cout, s} = x + y + cin.
//   x, y : digit operands
//   cin  : carry in from the previous digit
//   s    : digit sum
//   cout : carry out to the next digit
module digit_adder #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  logic [DIGIT:0] sum;

  assign sum       = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
  assign {cout, s} = sum;

endmodule

// File: rtl/multiword_addsub.sv
// Multi-cycle add/subtract unit. Operands are consumed DIGIT bits per cycle,
// least-significant digit first, with the carry chained through a register.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operation handshake (op, a, b sampled on accept)
//   op                  : 00 ADD, 01 SUB, 10 INC, 11 DEC
//   a, b                : operands (b ignored for INC/DEC)
//   out_valid/out_ready : result handshake, held under backpressure
//   result              : WIDTH-bit result, modulo 2^WIDTH
//   carry               : carry out of MSB (SUB/DEC: 1 = no borrow)
//   zero, negative      : result == 0, result MSB
//   overflow            : signed two's-complement overflow
module multiword_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NDIG - 1);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
    $error("multiword_addsub: WIDTH must be a positive multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;         // shifts right one digit per CALC cycle
  logic [WIDTH-1:0] b_q, b_d;         // mapped operand B', shifted likewise
  logic             c_q, c_d;         // carry chain, also the carry flag
  logic             nz_q, nz_d;       // any nonzero digit seen
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             amsb_q, amsb_d;   // operand MSBs kept for overflow, since
  logic             bmsb_q, bmsb_d;   // the shift registers lose them
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] b_map;
  logic             cin_map;
  logic [DIGIT-1:0] dsum;
  logic             dcout;
  logic [WIDTH-1:0] res_shift;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x    (a_q[DIGIT-1:0]),
    .y    (b_q[DIGIT-1:0]),
    .cin  (c_q),
    .s    (dsum),
    .cout (dcout)
  );

  // New digit enters at the top; after NDIG cycles every digit sits in place.
  if (NDIG == 1) begin : g_one
    assign res_shift = dsum;
  end else begin : g_many
    assign res_shift = {dsum, res_q[WIDTH-1:DIGIT]};
  end

  always_comb begin
    b_map   = b;
    cin_map = 1'b0;
    case (op_e'(op))
      OP_ADD: begin b_map = b;     cin_map = 1'b0; end
      OP_SUB: begin b_map = ~b;    cin_map = 1'b1; end
      OP_INC: begin b_map = '0;    cin_map = 1'b1; end
      OP_DEC: begin b_map = '1;    cin_map = 1'b0; end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    nz_d        = nz_q;
    res_d       = res_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    amsb_d      = amsb_q;
    bmsb_d      = bmsb_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b_map;
          c_d        = cin_map;
          k_d        = '0;
          nz_d       = 1'b0;
          amsb_d     = a[WIDTH-1];
          bmsb_d     = b_map[WIDTH-1];
          in_ready_d = 1'b0;
          state_d    = CALC;
        end
      end
      CALC: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        c_d   = dcout;
        nz_d  = nz_q | (|dsum);
        res_d = res_shift;
        k_d   = k_q + KW'(1);
        if (k_q == KLAST) begin
          // dsum[DIGIT-1] is the final result MSB on the last digit.
          zero_d      = ~(nz_q | (|dsum));
          ovf_d       = (amsb_q == bmsb_q) && (dsum[DIGIT-1] != amsb_q);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      nz_q        <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      amsb_q      <= 1'b0;
      bmsb_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      nz_q        <= nz_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      amsb_q      <= amsb_d;
      bmsb_q      <= bmsb_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign carry     = c_q;
  assign zero      = zero_q;
  assign negative  = res_q[WIDTH-1];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_multiword_addsub.sv
// Bench for multiword_addsub: an 8-bit-digit instance and a single-digit
// instance share all inputs, so they accept and retire in lockstep and each
// transaction is checked against both.
module tb_multiword_addsub;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, carry, zero, negative, overflow;
  logic [31:0] result;
  logic        in_ready1, out_valid1, carry1, zero1, negative1, overflow1;
  logic [31:0] result1;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  multiword_addsub #(.WIDTH(32), .DIGIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .negative(negative),
    .overflow(overflow)
  );

  multiword_addsub #(.WIDTH(32), .DIGIT(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .op(op), .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .carry(carry1), .zero(zero1), .negative(negative1),
    .overflow(overflow1)
  );

  // Reference: plain integer arithmetic. Returns {result, carry, zero, neg, ovf}.
  function automatic logic [35:0] model(input logic [1:0] o, input logic [31:0] av,
                                        input logic [31:0] bv);
    longint ua, ub, sa, sb, u, s;
    logic [63:0] ubits;
    logic c, v;
    ua = longint'(av);
    ub = longint'(bv);
    sa = longint'(signed'(av));
    sb = longint'(signed'(bv));
    case (o)
      2'b00:   begin u = ua + ub; s = sa + sb; c = (u >= 64'sd4294967296); end
      2'b01:   begin u = ua - ub; s = sa - sb; c = (ua >= ub); end
      2'b10:   begin u = ua + 1;  s = sa + 1;  c = (u >= 64'sd4294967296); end
      default: begin u = ua - 1;  s = sa - 1;  c = (ua >= 1); end
    endcase
    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    ubits = u;
    return {ubits[31:0], c, (ubits[31:0] == 32'd0), ubits[31], v};
  endfunction

  // One transaction on both instances; entered and left at #1 after a posedge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input int hold, input bit scramble, input string name);
    logic [35:0] exp;
    int w, cnt, cnt1;
    exp = model(o, av, bv);
    w = 0;
    while (!(in_ready && in_ready1) && w < 50) begin
      @(posedge clk); #1; w++;
    end
    nvec++;
    if ({in_ready, in_ready1} !== 2'b11) begin
      nerr++; $display("FAIL %s in_ready: got %b exp 11", name, {in_ready, in_ready1});
    end
    op = o; a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0; cnt1 = 0;
    while (!out_valid && cnt < 50) begin
      if (scramble) begin
        a = $urandom; b = $urandom; op = 2'($urandom);
      end
      @(posedge clk); #1;
      cnt++;
      if (out_valid1 && cnt1 == 0) cnt1 = cnt;
    end
    nvec++;
    if (cnt !== 4) begin
      nerr++; $display("FAIL %s latency8: got %0d exp 4", name, cnt);
    end
    nvec++;
    if (cnt1 !== 1) begin
      nerr++; $display("FAIL %s latency32: got %0d exp 1", name, cnt1);
    end
    nvec++;
    if ({result, carry, zero, negative, overflow} !== exp) begin
      nerr++; $display("FAIL %s dut8: got res=%h c%b z%b n%b v%b exp res=%h c%b z%b n%b v%b",
                       name, result, carry, zero, negative, overflow,
                       exp[35:4], exp[3], exp[2], exp[1], exp[0]);
    end
    nvec++;
    if ({result1, carry1, zero1, negative1, overflow1} !== exp) begin
      nerr++; $display("FAIL %s dut32: got res=%h c%b z%b n%b v%b exp res=%h c%b z%b n%b v%b",
                       name, result1, carry1, zero1, negative1, overflow1,
                       exp[35:4], exp[3], exp[2], exp[1], exp[0]);
    end
    for (int i = 0; i < hold; i++) begin
      if (scramble) begin
        a = $urandom; b = $urandom;
      end
      @(posedge clk); #1;
      nvec++;
      if ({out_valid, in_ready, result, carry, zero, negative, overflow} !== {2'b10, exp} ||
          {out_valid1, in_ready1} !== 2'b10) begin
        nerr++; $display("FAIL %s hold%0d: got v%b r%b res=%h flags=%b exp v1 r0 res=%h flags=%b",
                         name, i, out_valid, in_ready, result,
                         {carry, zero, negative, overflow}, exp[35:4], exp[3:0]);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    nvec++;
    if ({out_valid, in_ready, out_valid1, in_ready1} !== 4'b0101) begin
      nerr++; $display("FAIL %s retire: got %b exp 0101", name,
                       {out_valid, in_ready, out_valid1, in_ready1});
    end
  endtask

  task automatic test_reset();
    int stale;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if ({in_ready, out_valid, result, carry, zero, negative, overflow} !== {2'b10, 36'd0}) begin
      nerr++; $display("FAIL reset_init: got r%b v%b res=%h", in_ready, out_valid, result);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    op = OP_ADD; a = 32'h1234_5678; b = 32'h0101_0101; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({in_ready, out_valid, result, carry, zero, negative, overflow} !== {2'b10, 36'd0} ||
        {in_ready1, out_valid1, result1, carry1, zero1, negative1, overflow1} !== {2'b10, 36'd0}) begin
      nerr++; $display("FAIL reset_midcalc: got r%b v%b res=%h flags=%b exp r1 v0 res=0 flags=0",
                       in_ready, out_valid, result, {carry, zero, negative, overflow});
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid || out_valid1 || !in_ready) stale++;
    end
    nvec++;
    if (stale !== 0) begin
      nerr++; $display("FAIL reset_stale: got %0d bad cycles exp 0", stale);
    end
  endtask

  task automatic test_add_carry();
    run_op(OP_ADD, 32'h0000_00FF, 32'h0000_0001, 0, 1'b0, "add_digit_carry");
  endtask

  task automatic test_sub();
    run_op(OP_SUB, 32'd5, 32'd7, 0, 1'b0, "sub_borrow");
    run_op(OP_SUB, 32'd7, 32'd7, 0, 1'b0, "sub_zero");
  endtask

  task automatic test_overflow();
    run_op(OP_ADD, 32'h7FFF_FFFF, 32'd1, 0, 1'b0, "add_ovf");
    run_op(OP_SUB, 32'h8000_0000, 32'd1, 0, 1'b0, "sub_ovf");
    run_op(OP_ADD, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, "add_wrap");
  endtask

  task automatic test_unary();
    run_op(OP_INC, 32'hFFFF_FFFF, $urandom, 0, 1'b1, "inc_wrap");
    run_op(OP_DEC, 32'h0000_0000, $urandom, 0, 1'b1, "dec_wrap");
    run_op(OP_DEC, 32'h8000_0000, $urandom, 0, 1'b1, "dec_ovf");
  endtask

  task automatic test_backpressure();
    run_op(OP_SUB, 32'h1357_9BDF, 32'h2468_ACE0, 10, 1'b1, "backpressure");
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 31'h7FFF_FFFF};
      if ($urandom_range(0, 3) == 0) rb = ra;
      run_op(2'($urandom), ra, rb, $urandom_range(0, 3), 1'b1, "random");
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_op(OP_ADD, 32'h0000_00FF, 32'h0000_0001, 0, 1'b0, "b2b_digit32");
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub();
    test_overflow();
    test_unary();
    test_backpressure();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
